data_sel_scan: RTL and testbench
================================

// Module: data_sel_scan
// PURPOSE
//  Registered N-channel data selector: the parametrised successor of the 4:1 single-bit selector.
//  Picks one DATA_W-bit lane out of 2**SEL_W input lanes. Selection is either the sel port (manual) or an internal round-robin scan pointer.
//  Result, plus the lane index it came from, is held in a one-entry valid/ready output register.
//  Sits between parallel sensor/data lanes and a single serial consumer.
// PARAMETERS
//  DATA_W  8  width of each lane and of dout
//  SEL_W   2  select width; CH = 2**SEL_W lanes
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  mode       in   1           0 = manual (use sel), 1 = scan (use internal pointer)
//  sel        in   SEL_W       manual lane index
//  din        in   CH*DATA_W   lanes packed; lane k = din[k*DATA_W +: DATA_W]
//  in_valid   in   1           request to capture one lane this cycle
//  in_ready   out  1           = ~out_valid | out_ready (combinational)
//  out_valid  out  1           output register holds data
//  out_ready  in   1           consumer accepts dout
//  dout       out  DATA_W      captured lane data
//  out_ch     out  SEL_W       index of the lane captured in dout
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, dout=0, out_ch=0, scan ptr=0, FSM=EMPTY.
//  - FSM: EMPTY --accept--> FULL. FULL --out_ready & ~accept--> EMPTY. FULL --out_ready & accept--> FULL.
//  - accept = in_valid & in_ready. Latency: 1 clk from accept to out_valid/dout.
//  - Back-to-back accept at full throughput when out_ready=1.
//  - On accept: idx = mode ? ptr : sel; dout <= lane idx; out_ch <= idx.
//  - Scan pointer: advances only on accept while mode=1. Next = (ptr+1) mod CH, so CH-1 wraps to 0.
//    - Manual-mode accepts leave ptr unchanged.
//  - Mode change: mode sampled into mode_q. On the first cycle with mode=1 & mode_q=0, ptr reloads to 0.
//    - If that cycle also accepts: lane 0 is captured and ptr becomes 1.
//  - dout/out_ch are stable while out_valid=1 & out_ready=0. in_valid without in_ready is ignored (no queuing).
//  - Reset mid-transfer: pending data is discarded; out_valid drops immediately.
// CONFIGURATION
//  - DATA_SEL_MASK_EN defined: adds input ch_en [CH-1:0].
//    - Scan selects the lowest enabled lane at or above ptr, wrapping. Next ptr = that lane + 1 mod CH.
//    - ch_en == 0 in scan mode: in_ready=0, no capture.
//    - Manual mode ignores ch_en.
//  - DATA_SEL_MASK_EN undefined: no ch_en port; every lane is enabled.
// STRUCTURE
//  - Package data_sel_pkg: MODE_MANUAL=1'b0, MODE_SCAN=1'b1; FSM state enum {ST_EMPTY, ST_FULL}.
//  - Sub-module data_sel_ptr: scan pointer register, wrap, reload, and masked next-lane search.
//  - Top holds the lane mux, output register and FSM.
// TESTING
//  1. Manual, DATA_W=8, SEL_W=2, din={8'h44,8'h33,8'h22,8'h11}, sel=2, in_valid 1 clk, out_ready=1
//     -> next clk out_valid=1, dout=8'h33, out_ch=2.
//  2. Scan, in_valid held, out_ready=1, 6 clks -> out_ch sequence 0,1,2,3,0,1; dout follows lanes.
//  3. Backpressure: out_valid=1, out_ready=0 for 3 clks while in_valid=1
//     -> in_ready=0; dout and out_ch frozen; ptr does not move.
//  4. Manual->scan switch with ptr left at 3 -> first scan capture is lane 0, out_ch=0.
//  5. rst_n pulsed low mid-scan with out_valid=1 -> out_valid=0, dout=0 at once; next scan capture is lane 0.
//  6. DATA_SEL_MASK_EN, ch_en=4'b1010, scan -> out_ch 1,3,1,3.
//     ch_en=0 -> in_ready=0, out_valid stays 0.

Source files
------------

// File: rtl/data_sel_pkg.sv
// data_sel_pkg: mode encodings and output-register FSM states shared by
// the data_sel_scan lane selector and its scan-pointer sub-module.
// Optional lane-mask feature is enabled by defining DATA_SEL_MASK_EN.
package data_sel_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

endpackage

// File: rtl/data_sel_ptr.sv
// data_sel_ptr: round-robin scan pointer with reload on entry to scan mode
// and a wrapping search for the lowest enabled lane at or above the pointer.
// Lane mask input is tied all-ones by the top unless DATA_SEL_MASK_EN is defined.
module data_sel_ptr
   import data_sel_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic                    accept,
   input  logic [(1<<SEL_W)-1:0]   ch_en,
   output logic [SEL_W-1:0]        scan_idx,
   output logic                    scan_ok
);

   localparam int CH = 1 << SEL_W;

   logic [SEL_W-1:0] ptr;
   logic             mode_q;
   logic             reload;
   logic [SEL_W-1:0] base;

   // First scan cycle after manual mode starts the search from lane 0,
   // so a capture on that same cycle takes lane 0 and leaves ptr at 1.
   assign reload = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
   assign base   = reload ? '0 : ptr;

   // Wrapping search: first enabled lane starting at base.
   always_comb begin
      scan_idx = base;
      scan_ok  = 1'b0;
      for (int i = 0; i < CH; i++) begin
         if (!scan_ok && ch_en[base + SEL_W'(i)]) begin
            scan_idx = base + SEL_W'(i);
            scan_ok  = 1'b1;
         end
      end
   end

   // Pointer moves only on scan-mode captures; manual captures leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr    <= '0;
         mode_q <= MODE_MANUAL;
      end else begin
         mode_q <= mode;
         if (accept && mode == MODE_SCAN)
            ptr <= scan_idx + 1'b1;
         else if (reload)
            ptr <= '0;
      end
   end

endmodule

// File: rtl/data_sel_scan.sv
// data_sel_scan: picks one DATA_W lane of 2**SEL_W (manual sel or round-robin
// scan) into a one-entry valid/ready register; 1 clk accept-to-out_valid,
// full throughput; in_ready = ~out_valid | out_ready. Lane mask: DATA_SEL_MASK_EN.
module data_sel_scan
   import data_sel_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            mode,
   input  logic [SEL_W-1:0]                sel,
   input  logic [(1<<SEL_W)*DATA_W-1:0]    din,
`ifdef DATA_SEL_MASK_EN
   input  logic [(1<<SEL_W)-1:0]           ch_en,
`endif
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_W-1:0]               dout,
   output logic [SEL_W-1:0]                out_ch
);

   logic [(1<<SEL_W)-1:0] en_mask;
   logic [SEL_W-1:0]      scan_idx;
   logic                  scan_ok;
   logic [SEL_W-1:0]      idx;
   logic [DATA_W-1:0]     lane;
   logic                  accept;
   state_t                state, state_nxt;

`ifdef DATA_SEL_MASK_EN
   assign en_mask = ch_en;
`else
   assign en_mask = '1;
`endif

   data_sel_ptr #(.SEL_W(SEL_W)) u_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .accept   (accept),
      .ch_en    (en_mask),
      .scan_idx (scan_idx),
      .scan_ok  (scan_ok)
   );

   // Scan mode with no enabled lane cannot capture, so it refuses input.
   assign out_valid = (state == ST_FULL);
   assign in_ready  = (!out_valid || out_ready) && (mode == MODE_MANUAL || scan_ok);
   assign accept    = in_valid && in_ready;
   assign idx       = (mode == MODE_SCAN) ? scan_idx : sel;
   assign lane      = din[idx*DATA_W +: DATA_W];

   // State register for the one-entry output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_EMPTY;
      else
         state <= state_nxt;
   end

   // Next state: fill on accept, drain when consumed without a refill.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (accept) state_nxt = ST_FULL;
         ST_FULL:  if (out_ready && !accept) state_nxt = ST_EMPTY;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   // Data/index register; only loads on accept so it holds under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout   <= '0;
         out_ch <= '0;
      end else if (accept) begin
         dout   <= lane;
         out_ch <= idx;
      end
   end

endmodule

// File: tb/tb_data_sel_scan.sv
// tb_data_sel_scan: directed vector table plus hand sequences for reset,
// manual/scan selection, backpressure, mode switch and mid-transfer reset.
// Lane-mask sequence is included when DATA_SEL_MASK_EN is defined.
module tb_data_sel_scan;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] din;
`ifdef DATA_SEL_MASK_EN
   logic [3:0]  ch_en;
`endif
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  dout;
   logic [1:0]  out_ch;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic       iv;
      logic       ordy;
      logic       exp_ir;
      logic       exp_v;
      logic [7:0] exp_d;
      logic [1:0] exp_ch;
   } vec_t;

   vec_t vecs[17];

   always #5 clk = ~clk;

   data_sel_scan #(.DATA_W(8), .SEL_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .din       (din),
`ifdef DATA_SEL_MASK_EN
      .ch_en     (ch_en),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .out_ch    (out_ch)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Drive one cycle of inputs, check in_ready before the edge and outputs after it.
   task automatic step(input logic m, input logic [1:0] s, input logic iv, input logic ordy,
                       input logic eir, input logic ev, input logic [7:0] ed,
                       input logic [1:0] ech, input string tag);
      mode      = m;
      sel       = s;
      in_valid  = iv;
      out_ready = ordy;
      #1;
      chk({tag, " in_ready"}, 32'(in_ready), 32'(eir));
      @(posedge clk);
      #1;
      chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
      chk({tag, " dout"}, 32'(dout), 32'(ed));
      chk({tag, " out_ch"}, 32'(out_ch), 32'(ech));
   endtask

   initial begin
      // lane0=11 lane1=22 lane2=33 lane3=44
      din = 32'h44332211;
      //              mode  sel  iv    or    ir    v     dout   ch
      vecs[0]  = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2};
      vecs[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 2'd2};
      vecs[2]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0};
      vecs[3]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
      vecs[4]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2};
      vecs[5]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3};
      vecs[6]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0};
      vecs[7]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
      vecs[8]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1};
      vecs[9]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1};
      vecs[10] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1};
      vecs[11] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 2'd1};
      vecs[12] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2};
      vecs[13] = '{1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
      vecs[14] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0};
      vecs[15] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
      vecs[16] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 2'd1};

      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = 2'd0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
`ifdef DATA_SEL_MASK_EN
      ch_en     = 4'b1111;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset dout", 32'(dout), 32'd0);
      chk("reset out_ch", 32'(out_ch), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 17; i++)
         step(vecs[i].mode, vecs[i].sel, vecs[i].iv, vecs[i].ordy,
              vecs[i].exp_ir, vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_ch,
              $sformatf("vec%0d", i));

      // Reset mid-scan with data held: outputs clear at once, scan restarts at lane 0.
      step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0, "rst_pre0");
      step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1, "rst_pre1");
      step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1, "rst_hold");
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst dout", 32'(dout), 32'd0);
      chk("midrst out_ch", 32'(out_ch), 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0, "rst_post");

`ifdef DATA_SEL_MASK_EN
      // Masked scan: only lanes 1 and 3 enabled, then no lanes.
      ch_en = 4'b1010;
      step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1, "mask0");
      step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3, "mask1");
      step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1, "mask2");
      step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3, "mask3");
      ch_en = 4'b0000;
      step(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 2'd3, "mask_none0");
      step(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 2'd3, "mask_none1");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
